sem_mon_rx_parser: RTL and testbench

//  Reader side of the SEM monitor byte interface. Drains the first-word-fall-through (FWFT) receive FIFO (rxdata/rxread/rxempty).

---
 rtl/sem_mon_rx_parser.sv | 238 +++++++++++++++++++++++
 tb/tb_sem_mon_rx_parser.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sem_mon_rx_parser.sv
// SEM monitor receive parser.
// Drains the FWFT receive FIFO one byte every three cycles, splits the byte
// stream into lines and decodes "SC hh" state-change reports into sc_code.
// Also keeps a terminated-line counter and a sticky over-long-line flag.

module sem_mon_rx_parser #(
    parameter int LINE_MAX = 64,
    parameter int CNT_W    = 16
) (
    input  logic             icap_clk,
    input  logic             reset,
    input  logic [7:0]       monitor_rxdata,
    input  logic             monitor_rxempty,
    output logic             monitor_rxread,
    output logic             sc_valid,
    output logic [7:0]       sc_code,
    output logic             sc_err,
    output logic [CNT_W-1:0] line_cnt,
    output logic             line_long,
    input  logic             clr_stat
);

    localparam int                LEN_W     = $clog2(LINE_MAX + 2);
    localparam logic [LEN_W-1:0]  LEN_LIMIT = LEN_W'(LINE_MAX);
    localparam logic [LEN_W-1:0]  LEN_SAT   = LEN_W'(LINE_MAX + 1);

    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_SP = 8'h20;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_POP,
        RD_WAIT
    } rd_state_t;

    typedef enum logic [2:0] {
        P_START,
        P_S,
        P_SC,
        P_SP,
        P_H1,
        P_H2,
        P_TEXT,
        P_SKIP
    } p_state_t;

    rd_state_t        r_rd_state;
    rd_state_t        w_rd_next;
    logic             w_pop;

    p_state_t         r_p_state;
    p_state_t         w_p_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] w_len_next;
    logic [3:0]       r_hi;
    logic [3:0]       r_lo;
    logic             w_hi_load;
    logic             w_lo_load;
    logic             w_valid_next;
    logic             w_err_next;
    logic             w_line_inc;
    logic             w_long_set;

    logic             w_is_eol;
    logic             w_is_hex;
    logic [3:0]       w_nibble;

    logic             r_sc_valid;
    logic             r_sc_err;
    logic [7:0]       r_sc_code;
    logic [CNT_W-1:0] r_line_cnt;
    logic             r_line_long;

    // Read FSM state register.
    always_ff @(posedge icap_clk) begin
        if (reset) begin
            r_rd_state <= RD_IDLE;
        end else begin
            r_rd_state <= w_rd_next;
        end
    end

    // Read FSM: pop one byte, then idle one cycle so the empty flag can settle.
    always_comb begin
        w_rd_next = r_rd_state;
        w_pop     = 1'b0;
        case (r_rd_state)
            RD_IDLE: begin
                if (!monitor_rxempty) begin
                    w_rd_next = RD_POP;
                end
            end
            RD_POP: begin
                w_pop     = !monitor_rxempty && !reset;
                w_rd_next = RD_WAIT;
            end
            RD_WAIT: begin
                w_rd_next = RD_IDLE;
            end
            default: begin
                w_rd_next = RD_IDLE;
            end
        endcase
    end

    assign monitor_rxread = w_pop;

    // Classify the FIFO head byte: line terminator, hex digit and its value.
    always_comb begin
        w_is_eol = (monitor_rxdata == CH_CR) || (monitor_rxdata == CH_LF);
        w_is_hex = 1'b1;
        w_nibble = 4'h0;
        if (monitor_rxdata >= 8'h30 && monitor_rxdata <= 8'h39) begin
            w_nibble = monitor_rxdata[3:0];
        end else if ((monitor_rxdata >= 8'h41 && monitor_rxdata <= 8'h46) ||
                     (monitor_rxdata >= 8'h61 && monitor_rxdata <= 8'h66)) begin
            w_nibble = monitor_rxdata[3:0] + 4'd9;
        end else begin
            w_is_hex = 1'b0;
        end
    end

    // Parser next state: advances once per popped byte, tracks line length.
    always_comb begin
        w_p_next     = r_p_state;
        w_len_next   = r_len;
        w_hi_load    = 1'b0;
        w_lo_load    = 1'b0;
        w_valid_next = 1'b0;
        w_err_next   = 1'b0;
        w_line_inc   = 1'b0;
        w_long_set   = 1'b0;
        if (w_pop) begin
            if (w_is_eol) begin
                w_len_next = '0;
                w_line_inc = (r_len != '0);
                w_p_next   = P_START;
                case (r_p_state)
                    P_SP, P_H1: w_err_next   = 1'b1;
                    P_H2:       w_valid_next = 1'b1;
                    default:    ;
                endcase
            end else begin
                if (r_len != LEN_SAT) begin
                    w_len_next = r_len + LEN_W'(1);
                end
                if (r_len == LEN_LIMIT) begin
                    w_long_set = 1'b1;
                    w_p_next   = P_SKIP;
                end else begin
                    case (r_p_state)
                        P_START: w_p_next = (monitor_rxdata == CH_S)  ? P_S  : P_TEXT;
                        P_S:     w_p_next = (monitor_rxdata == CH_C)  ? P_SC : P_TEXT;
                        P_SC:    w_p_next = (monitor_rxdata == CH_SP) ? P_SP : P_TEXT;
                        P_SP: begin
                            if (w_is_hex) begin
                                w_p_next  = P_H1;
                                w_hi_load = 1'b1;
                            end else begin
                                w_p_next   = P_SKIP;
                                w_err_next = 1'b1;
                            end
                        end
                        P_H1: begin
                            if (w_is_hex) begin
                                w_p_next  = P_H2;
                                w_lo_load = 1'b1;
                            end else begin
                                w_p_next   = P_SKIP;
                                w_err_next = 1'b1;
                            end
                        end
                        P_H2: begin
                            w_p_next   = P_SKIP;
                            w_err_next = 1'b1;
                        end
                        default: w_p_next = r_p_state;
                    endcase
                end
            end
        end
    end

    // Parser registers: state, line length, captured nibbles and result pulses.
    always_ff @(posedge icap_clk) begin
        if (reset) begin
            r_p_state  <= P_START;
            r_len      <= '0;
            r_hi       <= 4'h0;
            r_lo       <= 4'h0;
            r_sc_valid <= 1'b0;
            r_sc_err   <= 1'b0;
            r_sc_code  <= 8'h00;
        end else begin
            r_p_state  <= w_p_next;
            r_len      <= w_len_next;
            r_sc_valid <= w_valid_next;
            r_sc_err   <= w_err_next;
            if (w_hi_load) begin
                r_hi <= w_nibble;
            end
            if (w_lo_load) begin
                r_lo <= w_nibble;
            end
            if (w_valid_next) begin
                r_sc_code <= {r_hi, r_lo};
            end
        end
    end

    // Statistics: clearing wins over a same-cycle count or long-line flag.
    always_ff @(posedge icap_clk) begin
        if (reset) begin
            r_line_cnt  <= '0;
            r_line_long <= 1'b0;
        end else if (clr_stat) begin
            r_line_cnt  <= '0;
            r_line_long <= 1'b0;
        end else begin
            if (w_line_inc) begin
                r_line_cnt <= r_line_cnt + CNT_W'(1);
            end
            if (w_long_set) begin
                r_line_long <= 1'b1;
            end
        end
    end

    assign sc_valid  = r_sc_valid;
    assign sc_err    = r_sc_err;
    assign sc_code   = r_sc_code;
    assign line_cnt  = r_line_cnt;
    assign line_long = r_line_long;

endmodule

// File: tb/tb_sem_mon_rx_parser.sv
// Testbench for sem_mon_rx_parser.
// A queue models the FWFT FIFO; a table of text lines with hand-computed
// results drives the main checks, followed by hand-written sequences for the
// long-line, clear-priority, mid-line reset and counter-wrap cases.

module tb_sem_mon_rx_parser;

    localparam int PERIOD = 10;
    localparam int NVEC   = 15;

    typedef struct {
        logic [95:0] txt;
        int          expValid;
        int          expErr;
        logic [7:0]  expCode;
        int          expLines;
        logic        expLong;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rxData;
    logic        rxEmpty;
    logic        clrStat;

    logic        rxRead;
    logic        scValid;
    logic [7:0]  scCode;
    logic        scErr;
    logic [15:0] lineCnt;
    logic        lineLong;

    logic        rxReadS;
    logic        scValidS;
    logic [7:0]  scCodeS;
    logic        scErrS;
    logic [2:0]  lineCntS;
    logic        lineLongS;

    byte unsigned fifo[$];
    longint       popTimes[$];
    vec_t         vecs[NVEC];

    int testsRun    = 0;
    int testsFailed = 0;
    int validCount  = 0;
    int errCount    = 0;
    int readTotal   = 0;
    int emptyReads  = 0;
    int bothHigh    = 0;
    int wideValid   = 0;
    int wideErr     = 0;
    int lockstepDiff = 0;
    logic prevValid = 1'b0;
    logic prevErr   = 1'b0;

    always #(PERIOD / 2) clk = ~clk;

    sem_mon_rx_parser #(.LINE_MAX(64), .CNT_W(16)) dut (
        .icap_clk        (clk),
        .reset           (reset),
        .monitor_rxdata  (rxData),
        .monitor_rxempty (rxEmpty),
        .monitor_rxread  (rxRead),
        .sc_valid        (scValid),
        .sc_code         (scCode),
        .sc_err          (scErr),
        .line_cnt        (lineCnt),
        .line_long       (lineLong),
        .clr_stat        (clrStat)
    );

    // Narrow-counter copy sharing all inputs; used to observe line_cnt wrap.
    sem_mon_rx_parser #(.LINE_MAX(64), .CNT_W(3)) dutSmall (
        .icap_clk        (clk),
        .reset           (reset),
        .monitor_rxdata  (rxData),
        .monitor_rxempty (rxEmpty),
        .monitor_rxread  (rxReadS),
        .sc_valid        (scValidS),
        .sc_code         (scCodeS),
        .sc_err          (scErrS),
        .line_cnt        (lineCntS),
        .line_long       (lineLongS),
        .clr_stat        (clrStat)
    );

    task automatic refreshFifo();
        rxEmpty = (fifo.size() == 0);
        rxData  = rxEmpty ? 8'h00 : fifo[0];
    endtask

    task automatic pushByte(input byte unsigned b);
        fifo.push_back(b);
        refreshFifo();
    endtask

    // FIFO pop on each read strobe seen at the clock edge.
    always @(posedge clk) begin
        if (rxRead) begin
            if (rxEmpty) emptyReads++;
            readTotal++;
            popTimes.push_back($time);
            #1;
            if (fifo.size() > 0) fifo.delete(0);
            refreshFifo();
        end
    end

    // Pulse bookkeeping sampled away from the active edge.
    always @(negedge clk) begin
        if (scValid) validCount++;
        if (scErr) errCount++;
        if (scValid && scErr) bothHigh++;
        if (scValid && prevValid) wideValid++;
        if (scErr && prevErr) wideErr++;
        prevValid = scValid;
        prevErr   = scErr;
        if (rxRead !== rxReadS) lockstepDiff++;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [95:0] txt);
        logic [7:0] b;
        @(negedge clk);
        for (int i = 11; i >= 0; i--) begin
            b = txt[8*i +: 8];
            if (b != 8'h00) pushByte(b);
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while (fifo.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL %s drain timeout: actual %0d bytes left, required 0", name, fifo.size());
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic setVec(input int i, input logic [95:0] t, input int v, input int e,
                          input logic [7:0] c, input int l, input logic lg);
        vecs[i].txt      = t;
        vecs[i].expValid = v;
        vecs[i].expErr   = e;
        vecs[i].expCode  = c;
        vecs[i].expLines = l;
        vecs[i].expLong  = lg;
    endtask

    initial begin
        int badGaps;
        int n;

        setVec(0,  "SC 02\r\n",      1, 0, 8'h02, 1,  1'b0);
        setVec(1,  "SC 1f\n",        1, 0, 8'h1F, 2,  1'b0);
        setVec(2,  "SCAN OK\n",      0, 0, 8'h1F, 3,  1'b0);
        setVec(3,  "SC 1G\n",        0, 1, 8'h1F, 4,  1'b0);
        setVec(4,  "SC 123\n",       0, 1, 8'h1F, 5,  1'b0);
        setVec(5,  "SC AB\r",        1, 0, 8'hAB, 6,  1'b0);
        setVec(6,  "\n\r\n",         0, 0, 8'hAB, 6,  1'b0);
        setVec(7,  "hello SC 05\n",  0, 0, 8'hAB, 7,  1'b0);
        setVec(8,  "SC\n",           0, 0, 8'hAB, 8,  1'b0);
        setVec(9,  "SC \n",          0, 1, 8'hAB, 9,  1'b0);
        setVec(10, "SC 7\n",         0, 1, 8'hAB, 10, 1'b0);
        setVec(11, "S\n",            0, 0, 8'hAB, 11, 1'b0);
        setVec(12, "SC c9\n",        1, 0, 8'hC9, 12, 1'b0);
        setVec(13, "SC  12\n",       0, 1, 8'hC9, 13, 1'b0);
        setVec(14, "sc 01\n",        0, 0, 8'hC9, 14, 1'b0);

        reset   = 1'b1;
        clrStat = 1'b0;
        refreshFifo();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Idle with an empty FIFO.
        repeat (100) @(negedge clk);
        checkOutput("idle reads", readTotal, 0);
        checkOutput("idle sc_valid", scValid, 0);
        checkOutput("idle sc_err", scErr, 0);
        checkOutput("idle sc_code", scCode, 8'h00);
        checkOutput("idle line_cnt", lineCnt, 0);
        checkOutput("idle line_long", lineLong, 0);
        checkOutput("idle pulses", validCount + errCount, 0);

        // Table of complete lines.
        for (int i = 0; i < NVEC; i++) begin
            validCount = 0;
            errCount   = 0;
            popTimes.delete();
            applyStimulus(vecs[i].txt);
            waitDrain($sformatf("v%0d", i));
            checkOutput($sformatf("v%0d valid pulses", i), validCount, vecs[i].expValid);
            checkOutput($sformatf("v%0d err pulses", i), errCount, vecs[i].expErr);
            checkOutput($sformatf("v%0d sc_code", i), scCode, vecs[i].expCode);
            checkOutput($sformatf("v%0d line_cnt", i), lineCnt, vecs[i].expLines);
            checkOutput($sformatf("v%0d line_long", i), lineLong, vecs[i].expLong);
            if (i == 0) begin
                badGaps = 0;
                for (int k = 1; k < popTimes.size(); k++) begin
                    if (popTimes[k] - popTimes[k-1] != 3 * PERIOD) badGaps++;
                end
                checkOutput("v0 pop count", popTimes.size(), 7);
                checkOutput("v0 pop spacing errors", badGaps, 0);
            end
        end

        // Over-long line: 70 bytes of 'x' then LF.
        validCount = 0;
        errCount   = 0;
        @(negedge clk);
        for (int i = 0; i < 70; i++) pushByte(8'h78);
        pushByte(8'h0A);
        waitDrain("long");
        checkOutput("long line_long", lineLong, 1);
        checkOutput("long line_cnt", lineCnt, 15);
        checkOutput("long err pulses", errCount, 0);

        applyStimulus("SC 04\n");
        waitDrain("after long");
        checkOutput("after long sc_code", scCode, 8'h04);
        checkOutput("after long valid pulses", validCount, 1);
        checkOutput("after long line_cnt", lineCnt, 16);
        checkOutput("after long line_long", lineLong, 1);

        // clr_stat in the same cycle as the EOL pop.
        @(negedge clk);
        pushByte(8'h61);
        pushByte(8'h62);
        pushByte(8'h63);
        pushByte(8'h0A);
        n = 0;
        while (!(rxRead && rxData == 8'h0A) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("clr eol found", (n < 100), 1);
        clrStat = 1'b1;
        @(posedge clk);
        #1 clrStat = 1'b0;
        waitDrain("clr");
        checkOutput("clr line_cnt", lineCnt, 0);
        checkOutput("clr line_long", lineLong, 0);

        // Reset after a partial "SC 0" line.
        applyStimulus("SC 0");
        waitDrain("partial");
        pulseReset();
        validCount = 0;
        errCount   = 0;
        applyStimulus("5\n");
        waitDrain("post reset");
        checkOutput("post reset valid pulses", validCount, 0);
        checkOutput("post reset err pulses", errCount, 0);
        checkOutput("post reset line_cnt", lineCnt, 1);
        checkOutput("post reset sc_code", scCode, 8'h00);

        // Counter wrap on the 3-bit copy.
        pulseReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus("a\n");
            waitDrain("wrap");
        end
        checkOutput("wrap before", lineCntS, 7);
        applyStimulus("a\n");
        waitDrain("wrap last");
        checkOutput("wrap after", lineCntS, 0);
        checkOutput("wrap main line_cnt", lineCnt, 8);

        checkOutput("read while empty", emptyReads, 0);
        checkOutput("valid and err together", bothHigh, 0);
        checkOutput("sc_valid wider than 1", wideValid, 0);
        checkOutput("sc_err wider than 1", wideErr, 0);
        checkOutput("copies out of step", lockstepDiff, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
